// File: rtl/rl_fifo_1r1w_ctrl.sv
// FIFO controller around an external 1R1W RAM with a one-cycle registered read.
// A 2-entry output buffer absorbs the read latency so pops can run every cycle.
module rl_fifo_1r1w_ctrl #(
  parameter int ABITS = 4,
  parameter int DBITS = 32
) (
  input  logic                   rst_ni,
  input  logic                   clk_i,
  input  logic                   clr_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [DBITS-1:0]       s_data_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [DBITS-1:0]       m_data_o,
  output logic [ABITS:0]         count_o,
  output logic [ABITS-1:0]       ram_waddr_o,
  output logic [DBITS-1:0]       ram_din_o,
  output logic                   ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [ABITS-1:0]       ram_raddr_o,
  input  logic [DBITS-1:0]       ram_dout_i
);

  localparam int DEPTH = 1 << ABITS;
  localparam logic [ABITS:0] FULL = (ABITS+1)'(DEPTH);

  logic [ABITS-1:0]       wr_ptr, rd_ptr;
  logic [ABITS:0]         ram_cnt;
  logic                   rd_pend;
  logic [1:0][DBITS-1:0]  ob, ob_nxt;
  logic [1:0]             ob_cnt, cap_idx;
  logic [2:0]             k;
  logic                   push, pop, issue;

  assign s_ready_o = (ram_cnt != FULL);
  assign m_valid_o = (ob_cnt != 2'd0);
  assign m_data_o  = ob[0];
  assign push      = s_valid_i & s_ready_o;
  assign pop       = m_valid_o & m_ready_i;

  // k is the buffer occupancy after this cycle's pop and capture; issue only
  // when the read returning next cycle is guaranteed a free slot.
  assign k       = 3'(ob_cnt) - 3'(pop) + 3'(rd_pend);
  assign issue   = (ram_cnt != '0) & (k <= 3'd1);
  assign cap_idx = ob_cnt - 2'(pop);

  assign count_o     = ram_cnt + (ABITS+1)'(rd_pend) + (ABITS+1)'(ob_cnt);
  assign ram_waddr_o = wr_ptr;
  assign ram_din_o   = s_data_i;
  assign ram_we_o    = push;
  assign ram_be_o    = '1;
  assign ram_raddr_o = rd_ptr;

  always_comb begin
    ob_nxt = ob;
    if (pop) ob_nxt[0] = ob[1];
    if (rd_pend) begin
      if (cap_idx == 2'd0) ob_nxt[0] = ram_dout_i;
      else                 ob_nxt[1] = ram_dout_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      ob_cnt  <= 2'd0;
      ob      <= '0;
    end else if (clr_i) begin
      // Flush drops any read in flight; stale ob data is masked by ob_cnt.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      ob_cnt  <= 2'd0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      ram_cnt <= ram_cnt + (ABITS+1)'(push) - (ABITS+1)'(issue);
      rd_pend <= issue;
      ob_cnt  <= k[1:0];
      ob      <= ob_nxt;
    end
  end

  ob_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rd_pend && !clr_i && cap_idx == 2'd2));

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// Directed + random bench for rl_fifo_1r1w_ctrl with a read-first RAM model
// and a queue scoreboard of accepted-but-not-popped words.
module tb_rl_fifo_1r1w_ctrl;
  localparam int ABITS = 4;
  localparam int DBITS = 32;
  localparam int DEPTH = 1 << ABITS;

  logic                   rst_ni, clk_i, clr_i;
  logic                   s_valid_i, s_ready_o, m_valid_o, m_ready_i;
  logic [DBITS-1:0]       s_data_i, m_data_o;
  logic [ABITS:0]         count_o;
  logic [ABITS-1:0]       ram_waddr_o, ram_raddr_o;
  logic [DBITS-1:0]       ram_din_o, ram_dout_i;
  logic                   ram_we_o;
  logic [(DBITS+7)/8-1:0] ram_be_o;

  rl_fifo_1r1w_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .rst_ni(rst_ni), .clk_i(clk_i), .clr_i(clr_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .count_o(count_o), .ram_waddr_o(ram_waddr_o), .ram_din_o(ram_din_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_raddr_o(ram_raddr_o),
    .ram_dout_i(ram_dout_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [DBITS-1:0] mem [DEPTH];
  always @(posedge clk_i) begin
    for (int b = 0; b < (DBITS+7)/8; b++)
      if (ram_we_o && ram_be_o[b]) mem[ram_waddr_o][b*8 +: 8] <= ram_din_o[b*8 +: 8];
    ram_dout_i <= mem[ram_raddr_o];
  end

  int tests = 0, fails = 0;
  logic [DBITS-1:0] q [$];
  logic acc, popd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: score at the falling edge, then return just after the rising edge.
  task automatic step();
    logic [DBITS-1:0] e;
    @(negedge clk_i);
    acc  = rst_ni && !clr_i && s_valid_i && s_ready_o;
    popd = rst_ni && !clr_i && m_valid_o && m_ready_i;
    if (rst_ni) chk("count_vs_model", 32'(count_o), 32'(q.size()));
    if (popd) begin
      if (q.size() == 0) chk("pop_with_model_empty", 32'(q.size()), 32'd1);
      else begin
        e = q.pop_front();
        chk("pop_data", m_data_o, e);
      end
    end
    if (clr_i) q.delete();
    if (acc) q.push_back(s_data_i);
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_one(input logic [DBITS-1:0] d);
    s_valid_i = 1'b1;
    s_data_i  = d;
    for (int b = 0; b < 20; b++) begin
      step();
      if (acc) break;
    end
    chk("push_accept", 32'(acc), 32'd1);
    s_valid_i = 1'b0;
  endtask

  task automatic fill(input int n);
    m_ready_i = 1'b0;
    for (int i = 1; i <= n; i++) push_one(32'(i));
  endtask

  task automatic drain();
    m_ready_i = 1'b1;
    for (int b = 0; b < 64 && q.size() != 0; b++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
    m_ready_i = 1'b0;
  endtask

  initial begin
    int pops;
    logic [DBITS-1:0] nxt;
    rst_ni = 1'b0; clr_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0; s_data_i = '0;
    repeat (2) step();
    chk("rst_m_valid", 32'(m_valid_o), 32'd0);
    chk("rst_s_ready", 32'(s_ready_o), 32'd1);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_m_data", m_data_o, 32'd0);
    chk("rst_raddr", 32'(ram_raddr_o), 32'd0);
    chk("rst_waddr", 32'(ram_waddr_o), 32'd0);
    chk("rst_we", 32'(ram_we_o), 32'd0);
    rst_ni = 1'b1;
    step();

    // Push-to-head latency
    s_valid_i = 1'b1; s_data_i = 32'hA5A5_0001;
    step();
    s_valid_i = 1'b0;
    chk("lat_c1_valid", 32'(m_valid_o), 32'd0);
    step();
    chk("lat_c2_valid", 32'(m_valid_o), 32'd0);
    step();
    chk("lat_c3_valid", 32'(m_valid_o), 32'd1);
    chk("lat_c3_data", m_data_o, 32'hA5A5_0001);
    drain();

    // Fill to capacity DEPTH+2, then check full-with-issue ready timing
    fill(DEPTH + 2);
    chk("full_count", 32'(count_o), 32'(DEPTH + 2));
    s_valid_i = 1'b1; s_data_i = 32'd19;
    repeat (3) begin
      step();
      chk("full_reject", 32'(acc), 32'd0);
    end
    s_valid_i = 1'b0;
    chk("full_s_ready", 32'(s_ready_o), 32'd0);
    m_ready_i = 1'b1;
    chk("full_issue_ready_same", 32'(s_ready_o), 32'd0);
    step();
    chk("full_issue_ready_next", 32'(s_ready_o), 32'd1);
    drain();

    // Back-to-back stream
    nxt = 32'd1000; s_data_i = nxt; s_valid_i = 1'b1; m_ready_i = 1'b1; pops = 0;
    for (int c = 0; c < 110; c++) begin
      if (c >= 100) s_valid_i = 1'b0;
      step();
      if (acc) begin nxt = nxt + 1; s_data_i = nxt; end
      if (c >= 3 && c < 100 && popd) pops++;
      if (c == 50) chk("stream_count", 32'(count_o), 32'd3);
    end
    chk("stream_pops", 32'(pops), 32'd97);
    drain();

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      s_valid_i = 1'($urandom_range(0, 1));
      m_ready_i = 1'($urandom_range(0, 1));
      s_data_i  = $urandom;
      step();
    end
    s_valid_i = 1'b0;
    drain();

    // Clear wins over simultaneous push and pop
    fill(DEPTH + 2);
    clr_i = 1'b1; s_valid_i = 1'b1; s_data_i = 32'hDEAD; m_ready_i = 1'b1;
    step();
    clr_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0;
    chk("clr_count", 32'(count_o), 32'd0);
    chk("clr_m_valid", 32'(m_valid_o), 32'd0);
    chk("clr_s_ready", 32'(s_ready_o), 32'd1);
    s_valid_i = 1'b1; s_data_i = 32'h5;
    step();
    s_valid_i = 1'b0;
    step(); step();
    chk("clr_push_valid", 32'(m_valid_o), 32'd1);
    chk("clr_push_data", m_data_o, 32'h5);
    drain();

    // Asynchronous reset mid-stream
    m_ready_i = 1'b0; s_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data_i = 32'h100 + 32'(i);
      step();
    end
    #2;
    rst_ni = 1'b0; s_valid_i = 1'b0;
    #1;
    chk("arst_m_valid", 32'(m_valid_o), 32'd0);
    chk("arst_m_data", m_data_o, 32'd0);
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_s_ready", 32'(s_ready_o), 32'd1);
    chk("arst_raddr", 32'(ram_raddr_o), 32'd0);
    chk("arst_we", 32'(ram_we_o), 32'd0);
    q.delete();
    step(); step();
    rst_ni = 1'b1;
    s_valid_i = 1'b1; s_data_i = 32'h77;
    step();
    s_valid_i = 1'b0;
    step();
    chk("arst_no_stale", 32'(m_valid_o), 32'd0);
    step();
    chk("arst_after_valid", 32'(m_valid_o), 32'd1);
    chk("arst_after_data", m_data_o, 32'h77);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rl_fifo_1r1w_ctrl.md
# rl_fifo_1r1w_ctrl

Synchronous FIFO controller that drives an external inferrable 1R1W RAM (registered read, one-cycle read latency, byte-enable writes). It provides a valid/ready push port upstream and a show-ahead valid/ready pop port downstream. A 2-entry output buffer hides the RAM read latency so the FIFO sustains one pop per cycle. Typical use: elastic buffering in front of bus/debug pipelines where the storage must map onto block RAM.

## Interface
- ABITS, 4, RAM address bits; RAM depth DEPTH = 2**ABITS; legal range ABITS >= 2
- DBITS, 32, data width
- rst_ni  in  1  reset, asynchronous, active low
- clk_i  in  1  clock, rising edge
- clr_i  in  1  synchronous flush, drops all contents
- s_valid_i  in  1  push request
- s_ready_o  out  1  push accept: ram_cnt != DEPTH
- s_data_i  in  DBITS  push data
- m_valid_o  out  1  head entry valid: ob_cnt != 0
- m_ready_i  in  1  pop request
- m_data_o  out  DBITS  head entry, ob[0]
- count_o  out  ABITS+1  entries held: ram_cnt + rd_pend + ob_cnt (max DEPTH+2)
- ram_waddr_o  out  ABITS  RAM write address = wr_ptr
- ram_din_o  out  DBITS  RAM write data = s_data_i
- ram_we_o  out  1  push = s_valid_i & s_ready_o
- ram_be_o  out  (DBITS+7)/8  all ones
- ram_raddr_o  out  ABITS  RAM read address = rd_ptr (register, no combinational path)
- ram_dout_i  in  DBITS  RAM read data, valid the cycle after rd_ptr was presented

## Operation
- State: wr_ptr, rd_ptr (ABITS, wrap modulo DEPTH); ram_cnt (0..DEPTH, entries written but not yet read-issued); rd_pend (1 = ram_dout_i carries a live entry this cycle); ob[0..1] plus ob_cnt (0..2).
- push = s_valid_i & s_ready_o: the RAM writes at wr_ptr, wr_ptr++.
- pop = m_valid_o & m_ready_i: ob shifts down by one, ob_cnt--.
- Read issue: k = ob_cnt - pop + rd_pend. issue = (ram_cnt != 0) & (k <= 1). On issue, rd_ptr++ and rd_pend <= 1; otherwise rd_pend <= 0.
- Capture: when rd_pend = 1, ram_dout_i is written into ob at index (ob_cnt - pop). The buffer must never overflow; overflow is an assertion failure.
- ram_cnt_next = ram_cnt + push - issue. Push and issue in the same cycle leave ram_cnt unchanged.
- Read of a slot whose rewrite lands on the same edge returns old data. This is correct by construction, because the slot was freed by the issue. No bypass logic.
- clr_i: pointers, ram_cnt, rd_pend and ob_cnt go to 0. clr_i has priority over push and pop in the same cycle. A pending RAM read is discarded.
- Reset state: all pointers and counters 0, ob data 0. Outputs: m_valid_o = 0, m_data_o = 0, s_ready_o = 1, count_o = 0, ram_raddr_o = 0, ram_waddr_o = 0, ram_we_o = 0 (given s_valid_i = 0).

## Timing
- Push at cycle t into an empty FIFO: RAM written at edge t+1, issue in t+1, ram_dout_i valid in t+2, m_valid_o = 1 in t+3. Push-to-head latency is 3 cycles.
- Steady state with m_ready_i = 1 and the RAM non-empty: ob_cnt = 1 and rd_pend = 1 every cycle, giving one pop per cycle with no bubbles.
- Capacity is DEPTH + 2 entries. s_ready_o depends only on RAM occupancy, so DEPTH further pushes are accepted after the output buffer fills.
- Full (ram_cnt = DEPTH) with a simultaneous issue: s_ready_o is still 0 in that cycle and rises the next cycle.
- Empty FIFO with pop: m_valid_o = 0, so nothing happens.
- Pointer wrap from DEPTH-1 to 0 needs no special handling.

## Test plan
- Reset with ABITS = 4 and DBITS = 32: m_valid_o = 0, s_ready_o = 1, count_o = 0. Push 0xA5A5_0001 at cycle 0 -> m_valid_o rises at cycle 3 with m_data_o = 0xA5A5_0001.
- With m_ready_i = 0, push 1..18 -> s_ready_o drops after 16 accepted pushes once the buffer holds 2. Total accepted = 18, count_o = 18. Drain then yields 1..18 in order.
- Continuous push and pop of 100 incrementing words -> one pop per cycle after the initial 3-cycle fill, ordered data, count_o stable at 3.
- Random s_valid_i/m_ready_i (50%) for 10k cycles against a reference queue -> data order intact, no ob overflow assertion, count_o matches the model.
- Fill to 18, then assert clr_i together with push and pop -> next cycle count_o = 0, m_valid_o = 0, s_ready_o = 1. A subsequent push of 0x5 appears 3 cycles later.
- Assert rst_ni low asynchronously mid-stream with ob_cnt = 2 and rd_pend = 1 -> outputs return to their reset values immediately. No stale data appears after release.
